mult_seq_sa: RTL and testbench
==============================

# mult_seq_sa

Parametrised sequential shift-and-add multiplier: control FSM plus datapath (multiplicand, multiplier, accumulator and iteration-counter registers) in one block. It is the generalised successor to the 8-bit control-unit-only multiplier. It adds:
- a configurable operand width;
- a signed/unsigned mode;
- a start/busy/done handshake.

It sits beside the other arithmetic units and is started by a host FSM that waits for `done`.

## Interface
- `N`, default 8, operand width in bits (N ≥ 2); product width is 2N.

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`
- `a`  in  N  multiplicand; sampled with `start`
- `b`  in  N  multiplier; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse, high in FINISH only
- `p`  out  2N  product register; holds its value until the next FINISH

## Operation
- States: IDLE, LOAD, CHECK, ADD, SHIFT, FINISH.
- Start capture:
  - IDLE with `start`=1 → LOAD.
  - On that same edge, the block latches `A=|a|` (zero-extended to 2N) and `B=|b|` (N bits).
  - It also latches `neg = signed_mode & (a[N-1]^b[N-1])`.
  - Magnitude is taken only when `signed_mode`=1; otherwise operands are used as-is.
- LOAD: `ACC←0`, `CNT←N`; → CHECK.
- CHECK:
  - `CNT`=0 → FINISH.
  - Else `B[0]`=1 → ADD.
  - Else → SHIFT.
- ADD: `ACC←ACC+A` (2N bits, cannot overflow); → SHIFT.
- SHIFT: `A←A<<1`, `B←B>>1` (logical), `CNT←CNT-1`; → CHECK.
- FINISH:
  - `p` is written on the edge entering FINISH: `p = neg ? -ACC : ACC` (2N-bit two's complement).
  - `done`=1; → IDLE.
- Width rules:
  - `CNT` is ceil(log2(N+1)) bits.
  - The most-negative operand −2^(N−1) has magnitude 2^(N−1), which fits in N unsigned bits; no special case is needed.
- `start` while `busy`=1 is ignored; `a`, `b` and `signed_mode` may change freely after capture.
- `start` held high in FINISH is not seen until IDLE. Back-to-back operations therefore have one IDLE cycle between them.
- Reset, including mid-operation: state→IDLE, `busy`=0, `done`=0, `p`=0; all internal registers are cleared.

## Timing
- Reset values of all outputs are 0.
- Let E0 be the edge that samples `start`, and k the number of 1 bits in the captured `B`.
- `done` is high in the cycle after edge E0 + 2N + k + 2. For N=8:
  - `b`=0 → 18 edges.
  - `b`=0xFF unsigned → 26 edges.
- `busy` rises after E0 and falls after the edge that leaves FINISH; `busy` and `done` are both high in FINISH.
- `p` changes only on the edge entering FINISH or on reset.

## Configuration
- `MULT_SEQ_EARLY_EXIT_EN` defined:
  - CHECK also goes to FINISH when `B`=0.
  - Latency becomes E0 + 2m + k + 2, where m is the index+1 of the highest set bit of `B` (m=0 when `B`=0).
  - Example: `b`=0 gives `done` after 2 edges.
- Undefined: fixed iteration count of N; latency as in Timing.
- Products are identical in both builds.

## Test plan
- Unsigned, N=8: a=13, b=11, signed_mode=0 → `p`=0x008F, `done` one cycle, 2·8+3+2=21 edges after start.
- Signed, N=8: a=0xFD (−3), b=0x05 → `p`=0xFFF1. Also a=0x80, b=0x80 → `p`=0x4000. Also a=0x80, b=0x01 → `p`=0xFF80.
- Latency, N=8: b=0 → `done` at edge 18 (macro off) or 2 (macro on). b=0xFF unsigned → 26 in both builds, `p`=0xFE01.
- Handshake: pulse `start` with new operands while `busy`=1 → ignored. The first product completes unchanged, and the second op starts only from IDLE.
- Reset mid-op: assert `rst` in ADD → `busy`=`done`=`p`=0 immediately. A subsequent start of 7×6 → `p`=42.
- Parameter sweep: N=4 and N=16, random signed/unsigned operands (including the extremes) against the arithmetic product, checking the latency formula.

Source files
------------

// File: rtl/mult_seq_sa.sv
`timescale 1ns/1ps
// mult_seq_sa: sequential shift-and-add multiplier (N-bit operands, 2N-bit product)
// with signed/unsigned mode and start/busy/done handshake. Define MULT_SEQ_EARLY_EXIT_EN to stop once B is zero.
module mult_seq_sa #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_SHIFT  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [2:0]     state_q, state_d;
    logic [2*N-1:0] a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [2*N-1:0] p_q, p_d;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           loop_exit;

    // Negating -2^(N-1) wraps back to 2^(N-1), which is the correct unsigned magnitude.
    assign a_mag = (signed_mode && a[N-1]) ? -a : a;
    assign b_mag = (signed_mode && b[N-1]) ? -b : b;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    assign loop_exit = (cnt_q == '0) || (b_q == '0);
`else
    assign loop_exit = (cnt_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = {{N{1'b0}}, a_mag};
                    b_d     = b_mag;
                    neg_d   = signed_mode & (a[N-1] ^ b[N-1]);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d   = '0;
                cnt_d   = CNT_INIT;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (loop_exit) begin
                    p_d     = neg_q ? -acc_q : acc_q;
                    state_d = S_FINISH;
                end else if (b_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADD: begin
                acc_d   = acc_q + a_q;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q - CNT_ONE;
                state_d = S_CHECK;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FINISH);
    assign p    = p_q;

endmodule

// File: tb/tb_mult_seq_sa.sv
`timescale 1ns/1ps
// Scoreboard bench for mult_seq_sa: directed and random N=8 traffic plus random sweeps at N=4 and N=16,
// checked against plain-arithmetic products and the closed-form latency.
module tb_mult_seq_sa;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;
    int sweeps_finished = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operand value as the arithmetic integer it represents.
    function automatic longint sval(longint v, int w, bit sm);
        return (sm && v[w-1]) ? v - (longint'(1) << w) : v;
    endfunction

    function automatic longint model_prod(longint av, longint bv, int w, bit sm);
        longint r = sval(av, w, sm) * sval(bv, w, sm);
        return r & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Edges from the start-sampling edge to the edge entering FINISH.
    function automatic int model_lat(longint bv, int w, bit sm);
        longint mag = sval(bv, w, sm);
        int k = 0;
        int m = 0;
        int iters;
        if (mag < 0) mag = -mag;
        for (int i = 0; i < w; i++) begin
            if (mag[i]) begin
                k++;
                m = i + 1;
            end
        end
`ifdef MULT_SEQ_EARLY_EXIT_EN
        iters = m;
`else
        iters = w;
`endif
        return 2 * iters + k + 2;
    endfunction

    function automatic longint pick(int w);
        longint mask = (longint'(1) << w) - 1;
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return mask;
            3:       return longint'(1) << (w - 1);
            4:       return (longint'(1) << (w - 1)) - 1;
            default: return longint'({$urandom, $urandom}) & mask;
        endcase
    endfunction

    // ---------------- N=8 instance ----------------
    logic           rst, start, sm;
    logic [N-1:0]   a, b;
    logic           busy, done;
    logic [2*N-1:0] p;

    mult_seq_sa #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy), .done(done), .p(p)
    );

    typedef struct {
        logic [2*N-1:0] p;
        int             due;
        int             id;
    } exp8_t;

    exp8_t          q8[$];
    exp8_t          mon_e;
    logic [2*N-1:0] p_prev = '0;
    bit             p_moved = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            p_prev  = '0;
            p_moved = 1'b0;
        end else begin
            if (done) begin
                if (q8.size() == 0) begin
                    check("unexpected_done", q8.size(), 1);
                end else begin
                    mon_e = q8.pop_front();
                    check("product", p, mon_e.p);
                    check("latency", cyc, mon_e.due);
                    check("busy_in_finish", busy, 1);
                    check("p_stable_between_ops", p_moved, 0);
                    $display("[TB] N=8 op %0d: p=0x%04h expected 0x%04h at cycle %0d", mon_e.id, p, mon_e.p, cyc);
                end
                p_moved = 1'b0;
            end else if (p !== p_prev) begin
                p_moved = 1'b1;
            end
            p_prev = p;
        end
    end

    int op_id = 0;

    task automatic issue8(bit smv, logic [N-1:0] av, logic [N-1:0] bv, logic [2*N-1:0] ep, int lat);
        exp8_t e;
        @(negedge clk);
        start = 1'b1; sm = smv; a = av; b = bv;
        @(posedge clk); #1;
        e.p = ep; e.due = cyc + lat; e.id = op_id++;
        q8.push_back(e);
        start = 1'b0; sm = 1'($urandom); a = N'($urandom); b = N'($urandom);
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
        check("queue_drained", q8.size(), 0);
    endtask

    typedef struct packed {
        bit             sm;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        int             lat_off;
        int             lat_on;
    } dir_t;

    localparam int NDIR = 8;
    dir_t dirs [NDIR] = '{
        '{1'b0, 8'd13,  8'd11,  16'h008F, 21, 13},
        '{1'b1, 8'hFD,  8'h05,  16'hFFF1, 20, 10},
        '{1'b1, 8'h80,  8'h80,  16'h4000, 19, 19},
        '{1'b1, 8'h80,  8'h01,  16'hFF80, 19,  5},
        '{1'b0, 8'hAB,  8'h00,  16'h0000, 18,  2},
        '{1'b0, 8'hFF,  8'hFF,  16'hFE01, 26, 26},
        '{1'b1, 8'h7F,  8'h80,  16'hC080, 19, 19},
        '{1'b1, 8'hFF,  8'hFF,  16'h0001, 19,  5}
    };

    initial begin
        exp8_t  e;
        int     n;
        int     lat;
        longint av, bv;
        bit     smv;

        rst = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_p", p, 0);
        rst = 1'b0;

        for (int i = 0; i < NDIR; i++) begin
`ifdef MULT_SEQ_EARLY_EXIT_EN
            lat = dirs[i].lat_on;
`else
            lat = dirs[i].lat_off;
`endif
            issue8(dirs[i].sm, dirs[i].a, dirs[i].b, dirs[i].p, lat);
            wait_idle8();
        end

        // start pulsed while busy must be ignored
        issue8(1'b1, 8'hFD, 8'h05, 16'hFFF1, model_lat(8'h05, N, 1'b1));
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        wait_idle8();

        // start held through FINISH: second op begins only after one IDLE cycle
        @(negedge clk);
        start = 1'b1; sm = 1'b0; a = 8'd13; b = 8'd11;
        @(posedge clk); #1;
        e.p = 16'h008F; e.due = cyc + model_lat(8'd11, N, 1'b0); e.id = op_id++;
        q8.push_back(e);
        a = 8'd9; b = 8'd10;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("first_done_seen", done, 1);
        e.p = 16'd90; e.due = cyc + 2 + model_lat(8'd10, N, 1'b0); e.id = op_id++;
        q8.push_back(e);
        @(negedge clk);
        check("idle_gap", busy, 0);
        @(posedge clk); #1;
        check("second_start", busy, 1);
        start = 1'b0;
        wait_idle8();

        // reset asserted while the FSM sits in ADD
        @(negedge clk);
        start = 1'b1; sm = 1'b0; a = 8'd7; b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midop_rst_busy", busy, 0);
        check("midop_rst_done", done, 0);
        check("midop_rst_p", p, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue8(1'b0, 8'd7, 8'd6, 16'd42, model_lat(8'd6, N, 1'b0));
        wait_idle8();

        for (int i = 0; i < 40; i++) begin
            smv = 1'($urandom);
            av  = pick(N);
            bv  = pick(N);
            issue8(smv, N'(av), N'(bv), (2*N)'(model_prod(av, bv, N, smv)), model_lat(bv, N, smv));
            wait_idle8();
        end

        n = 0;
        while (sweeps_finished < 2 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("sweeps_finished", sweeps_finished, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // ---------------- N=4 and N=16 sweeps ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int W = (gi == 0) ? 4 : 16;

        logic           rst_s, start_s, sm_s;
        logic [W-1:0]   a_s, b_s;
        logic           busy_s, done_s;
        logic [2*W-1:0] p_s;

        mult_seq_sa #(.N(W)) dut_s (
            .clk(clk), .rst(rst_s), .start(start_s), .signed_mode(sm_s),
            .a(a_s), .b(b_s), .busy(busy_s), .done(done_s), .p(p_s)
        );

        longint qp[$];
        int     qd[$];

        always @(negedge clk) begin
            if (!rst_s && done_s) begin
                if (qp.size() == 0) begin
                    check($sformatf("w%0d_unexpected_done", W), qp.size(), 1);
                end else begin
                    $display("[TB] N=%0d op: p=0x%0h expected 0x%0h at cycle %0d", W, p_s, qp[0], cyc);
                    check($sformatf("w%0d_product", W), p_s, qp.pop_front());
                    check($sformatf("w%0d_latency", W), cyc, qd.pop_front());
                end
            end
        end

        initial begin
            longint av, bv;
            bit     smv;
            int     n;
            rst_s = 1'b1; start_s = 1'b0; sm_s = 1'b0; a_s = '0; b_s = '0;
            repeat (3) @(negedge clk);
            rst_s = 1'b0;
            for (int i = 0; i < 30; i++) begin
                smv = 1'($urandom);
                av  = pick(W);
                bv  = pick(W);
                @(negedge clk);
                start_s = 1'b1; sm_s = smv; a_s = W'(av); b_s = W'(bv);
                @(posedge clk); #1;
                qp.push_back(model_prod(av, bv, W, smv));
                qd.push_back(cyc + model_lat(bv, W, smv));
                start_s = 1'b0; a_s = W'($urandom); b_s = W'($urandom);
                n = 0;
                while (busy_s && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("w%0d_idle_reached", W), busy_s, 0);
            end
            check($sformatf("w%0d_queue_drained", W), qp.size(), 0);
            sweeps_finished++;
        end
    end

endmodule
